// File: rtl/multicycle_core.sv
// multicycle_core: multi-cycle 32-bit R/I/J core with handshaked instruction
// and data memories. FETCH/DECODE/EXEC/MEM/WB are sequenced by one FSM, and
// the core reports retire, halted and illegal status.
// Optional feature macro: CORE_LR_EN. When it is defined, jal/jr use a dedicated
// link register in place of register NREGS-1 and the jr rs operand.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_FETCH  | imem request outstanding; latch instruction on ack
// S_DECODE | read rs/rt, classify; halt or illegal go to S_HALT
// S_EXEC   | ALU / address / branch target; branches commit here
// S_MEM    | dmem request outstanding; sw commits on ack
// S_WB     | register write and PC update; commit cycle
// S_HALT   | terminal until rst
module multicycle_core #(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] pc_out,
    output logic            retire,
    output logic            halted,
    output logic            illegal
);
    localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
    typedef enum logic [3:0] {C_ALU, C_ADDI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_JR, C_HALT, C_ILL} cls_t;

    state_t          state_q;
    logic [XLEN-1:0] pc_q, rs_val_q, rt_val_q, wb_val_q, dmem_addr_q, dmem_wdata_q;
    logic [31:0]     ir_q;
    logic            imem_req_q, dmem_req_q, dmem_we_q, halted_q, illegal_q;
    logic [XLEN-1:0] regs_q [NREGS];
`ifdef CORE_LR_EN
    logic [XLEN-1:0] lr_q;
`endif

    cls_t            cls;
    logic [5:0]      op, funct;
    logic [4:0]      shamt;
    logic [RW-1:0]   rs_idx, rt_idx, rd_idx, wb_idx;
    logic [XLEN-1:0] imm_sx, pc_plus4, alu_d, wb_d, next_pc_d, jr_tgt;

    assign op       = ir_q[31:26];
    assign funct    = ir_q[5:0];
    assign shamt    = ir_q[10:6];
    assign rs_idx   = ir_q[21 +: RW];
    assign rt_idx   = ir_q[16 +: RW];
    assign rd_idx   = ir_q[11 +: RW];
    assign imm_sx   = {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};
    assign pc_plus4 = pc_q + XLEN'(4);
`ifdef CORE_LR_EN
    assign jr_tgt   = lr_q;
`else
    assign jr_tgt   = rs_val_q;
`endif

    // Classify the latched instruction; anything unlisted is illegal.
    always_comb begin
        cls = C_ILL;
        case (op)
            6'h00: begin
                case (funct)
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02: cls = C_ALU;
                    6'h08:   cls = C_JR;
                    default: cls = C_ILL;
                endcase
            end
            6'h08:   cls = C_ADDI;
            6'h23:   cls = C_LW;
            6'h2B:   cls = C_SW;
            6'h04:   cls = C_BEQ;
            6'h02:   cls = C_J;
            6'h03:   cls = C_JAL;
            6'h3F:   cls = C_HALT;
            default: cls = C_ILL;
        endcase
    end

    // R-type ALU result.
    always_comb begin
        alu_d = '0;
        case (funct)
            6'h20:   alu_d = rs_val_q + rt_val_q;
            6'h22:   alu_d = rs_val_q - rt_val_q;
            6'h24:   alu_d = rs_val_q & rt_val_q;
            6'h25:   alu_d = rs_val_q | rt_val_q;
            6'h2A:   alu_d = {{(XLEN-1){1'b0}}, ($signed(rs_val_q) < $signed(rt_val_q))};
            6'h00:   alu_d = rt_val_q << shamt;
            6'h02:   alu_d = rt_val_q >> shamt;
            default: alu_d = '0;
        endcase
    end

    // Writeback value, destination index and next PC for the latched instruction.
    always_comb begin
        wb_d      = alu_d;
        wb_idx    = rd_idx;
        next_pc_d = pc_plus4;
        case (cls)
            C_ADDI: begin wb_d = rs_val_q + imm_sx; wb_idx = rt_idx; end
            C_LW:   wb_idx = rt_idx;
            C_JAL: begin
                wb_d      = pc_plus4;
                wb_idx    = RW'(NREGS - 1);
                next_pc_d = {pc_plus4[XLEN-1:28], ir_q[25:0], 2'b00};
            end
            C_BEQ:  if (rs_val_q == rt_val_q) next_pc_d = pc_plus4 + (imm_sx << 2);
            C_J:    next_pc_d = {pc_plus4[XLEN-1:28], ir_q[25:0], 2'b00};
            C_JR:   next_pc_d = jr_tgt;
            default: ;
        endcase
    end

    // Main sequencer: state, PC, register file and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            ir_q         <= '0;
            rs_val_q     <= '0;
            rt_val_q     <= '0;
            wb_val_q     <= '0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            imem_req_q   <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            halted_q     <= 1'b0;
            illegal_q    <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
`ifdef CORE_LR_EN
            lr_q         <= '0;
`endif
        end else begin
            case (state_q)
                S_FETCH: begin
                    // req is only low here in the first cycle after reset
                    if (!imem_req_q) begin
                        imem_req_q <= 1'b1;
                    end else if (imem_ack) begin
                        ir_q       <= imem_rdata;
                        imem_req_q <= 1'b0;
                        state_q    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    rs_val_q <= regs_q[rs_idx];
                    rt_val_q <= regs_q[rt_idx];
                    if (cls == C_ILL) begin
                        halted_q  <= 1'b1;
                        illegal_q <= 1'b1;
                        state_q   <= S_HALT;
                    end else if (cls == C_HALT) begin
                        halted_q  <= 1'b1;
                        state_q   <= S_HALT;
                    end else begin
                        state_q   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    wb_val_q <= wb_d;
                    case (cls)
                        C_LW, C_SW: begin
                            dmem_addr_q  <= rs_val_q + imm_sx;
                            dmem_wdata_q <= rt_val_q;
                            dmem_we_q    <= (cls == C_SW);
                            dmem_req_q   <= 1'b1;
                            state_q      <= S_MEM;
                        end
                        C_BEQ, C_J, C_JR: begin
                            pc_q       <= next_pc_d;
                            imem_req_q <= 1'b1;
                            state_q    <= S_FETCH;
                        end
                        default: state_q <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        if (cls == C_SW) begin
                            pc_q       <= pc_plus4;
                            imem_req_q <= 1'b1;
                            state_q    <= S_FETCH;
                        end else begin
                            wb_val_q <= dmem_rdata;
                            state_q  <= S_WB;
                        end
                    end
                end
                S_WB: begin
`ifdef CORE_LR_EN
                    if (cls == C_JAL) lr_q <= wb_val_q;
                    else if (wb_idx != '0) regs_q[wb_idx] <= wb_val_q;
`else
                    if (wb_idx != '0) regs_q[wb_idx] <= wb_val_q;
`endif
                    pc_q       <= next_pc_d;
                    imem_req_q <= 1'b1;
                    state_q    <= S_FETCH;
                end
                default: ;
            endcase
        end
    end

    // Commit happens in WB, in EXEC for control flow, and on the sw data ack.
    assign retire = (state_q == S_WB)
                 || ((state_q == S_EXEC) && ((cls == C_BEQ) || (cls == C_J) || (cls == C_JR)))
                 || ((state_q == S_MEM) && dmem_ack && (cls == C_SW));

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign pc_out     = pc_q;
    assign halted     = halted_q;
    assign illegal    = illegal_q;
endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: instruction/data memory responders with
// configurable wait states, an activity log, and one task per scenario.
module tb_multicycle_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [31:0] pc_out;
    logic        retire, halted, illegal;

    int checks = 0;
    int failures = 0;

    logic [31:0] prog [0:63];
    logic [31:0] dm   [0:15];
    int          dwait = 0;
    bit          ihold = 1'b0;
    int          dcnt = 0;

    int          cyc = 0, nf = 0, nr = 0, nd = 0, nst = 0, req_after_halt = 0, dreq_run = 0;
    int          fetch_cyc [0:255];
    logic [31:0] fetch_addr [0:255];
    int          ret_cyc [0:255];
    int          dreq_len [0:255];
    logic [31:0] st_addr [0:255];
    logic [31:0] st_data [0:255];

    multicycle_core dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .pc_out(pc_out), .retire(retire), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Memory responders (driven at negedge) followed by the activity log.
    always @(negedge clk) begin
        imem_ack = 1'b0;
        if (imem_req && !ihold) begin
            imem_ack   = 1'b1;
            imem_rdata = prog[imem_addr[7:2]];
        end
        dmem_ack = 1'b0;
        if (dmem_req) begin
            if (dcnt >= dwait) begin
                dmem_ack = 1'b1;
                dcnt = 0;
                if (dmem_we) dm[dmem_addr[5:2]] = dmem_wdata;
                else dmem_rdata = dm[dmem_addr[5:2]];
            end else begin
                dcnt++;
            end
        end else begin
            dcnt = 0;
        end
        #1;
        cyc++;
        if (imem_req && imem_ack && nf < 256) begin
            fetch_cyc[nf] = cyc; fetch_addr[nf] = imem_addr; nf++;
        end
        if (retire && nr < 256) begin ret_cyc[nr] = cyc; nr++; end
        if (dmem_req) dreq_run++;
        if (dmem_req && dmem_ack) begin
            if (nd < 256) dreq_len[nd] = dreq_run;
            nd++;
            dreq_run = 0;
            if (dmem_we && nst < 256) begin st_addr[nst] = dmem_addr; st_data[nst] = dmem_wdata; nst++; end
        end
        if (halted && (imem_req || dmem_req)) req_after_halt++;
    end

    function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [4:0] sh, logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction
    function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] enc_j(logic [5:0] op, logic [25:0] a);
        return {op, a};
    endfunction

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) prog[i] = 32'hFC00_0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic run_to_halt(input string name, input int budget);
        int n = 0;
        while (!halted && n < budget) begin tick(); n++; end
        checks++;
        if (halted !== 1'b1) begin failures++; $display("FAIL %s_timeout: halted=%b after %0d cycles, required 1", name, halted, budget); end
    endtask

    task automatic load_alu_prog();
        clear_prog();
        prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        prog[1] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
        prog[2] = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
        prog[3] = enc_r(5'd2, 5'd1, 5'd4, 5'd0, 6'h2A);
        prog[4] = enc_r(5'd0, 5'd1, 5'd5, 5'd2, 6'h00);
        prog[5] = enc_i(6'h2B, 5'd0, 5'd3, 16'd0);
        prog[6] = enc_i(6'h2B, 5'd0, 5'd4, 16'd4);
        prog[7] = enc_i(6'h2B, 5'd0, 5'd5, 16'd8);
        prog[8] = 32'hFC00_0000;
    endtask

    task automatic test_reset();
        load_alu_prog();
        rst = 1'b1;
        repeat (2) tick();
        checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h want 00000000", pc_out); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_imem_req: got %b want 0", imem_req); end
        checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin failures++; $display("FAIL reset_dmem: req=%b we=%b want 0 0", dmem_req, dmem_we); end
        checks++; if (halted !== 1'b0 || illegal !== 1'b0 || retire !== 1'b0) begin failures++; $display("FAIL reset_status: halted=%b illegal=%b retire=%b want 0 0 0", halted, illegal, retire); end
        rst = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL release_fetch: req=%b addr=%h want 1 00000000", imem_req, imem_addr); end
    endtask

    task automatic test_alu();
        int f0, r0, s0, h0;
        load_alu_prog();
        f0 = nf; r0 = nr; s0 = nst;
        do_reset();
        run_to_halt("alu", 200);
        h0 = req_after_halt;
        repeat (5) tick();
        checks++; if (nr - r0 !== 8) begin failures++; $display("FAIL alu_retire_count: got %0d want 8", nr - r0); end
        checks++; if (ret_cyc[r0] - fetch_cyc[f0] + 1 !== 4) begin failures++; $display("FAIL alu_latency: got %0d want 4", ret_cyc[r0] - fetch_cyc[f0] + 1); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (ret_cyc[r0+i+1] - ret_cyc[r0+i] !== 4) begin failures++; $display("FAIL alu_retire_gap%0d: got %0d want 4", i, ret_cyc[r0+i+1] - ret_cyc[r0+i]); end
        end
        checks++; if (st_data[s0] !== 32'd2) begin failures++; $display("FAIL alu_add_r3: got %h want 00000002", st_data[s0]); end
        checks++; if (st_data[s0+1] !== 32'd1) begin failures++; $display("FAIL alu_slt_r4: got %h want 00000001", st_data[s0+1]); end
        checks++; if (st_data[s0+2] !== 32'd20) begin failures++; $display("FAIL alu_sll_r5: got %h want 00000014", st_data[s0+2]); end
        checks++; if (halted !== 1'b1 || illegal !== 1'b0) begin failures++; $display("FAIL alu_halt_status: halted=%b illegal=%b want 1 0", halted, illegal); end
        checks++; if (pc_out !== 32'h20) begin failures++; $display("FAIL alu_halt_pc: got %h want 00000020", pc_out); end
        checks++; if (req_after_halt !== h0 || nr - r0 !== 8) begin failures++; $display("FAIL alu_quiet_after_halt: reqs=%0d retires=%0d want %0d 8", req_after_halt, nr - r0, h0); end
    endtask

    task automatic test_mem_wait();
        int f0, r0, s0, d0;
        clear_prog();
        prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        prog[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'd8);
        prog[2] = enc_i(6'h23, 5'd0, 5'd6, 16'd8);
        prog[3] = enc_i(6'h2B, 5'd0, 5'd6, 16'd12);
        dwait = 3;
        f0 = nf; r0 = nr; s0 = nst; d0 = nd;
        do_reset();
        run_to_halt("mem", 300);
        dwait = 0;
        checks++; if (st_addr[s0] !== 32'd8 || st_data[s0] !== 32'd5) begin failures++; $display("FAIL mem_sw: addr=%h data=%h want 00000008 00000005", st_addr[s0], st_data[s0]); end
        checks++; if (dreq_len[d0] !== 4) begin failures++; $display("FAIL mem_sw_req_len: got %0d want 4", dreq_len[d0]); end
        checks++; if (dreq_len[d0+1] !== 4) begin failures++; $display("FAIL mem_lw_req_len: got %0d want 4", dreq_len[d0+1]); end
        checks++; if (ret_cyc[r0+1] - fetch_cyc[f0+1] + 1 !== 7) begin failures++; $display("FAIL mem_sw_latency: got %0d want 7", ret_cyc[r0+1] - fetch_cyc[f0+1] + 1); end
        checks++; if (ret_cyc[r0+2] - fetch_cyc[f0+2] + 1 !== 8) begin failures++; $display("FAIL mem_lw_latency: got %0d want 8", ret_cyc[r0+2] - fetch_cyc[f0+2] + 1); end
        checks++; if (st_addr[s0+1] !== 32'd12 || st_data[s0+1] !== 32'd5) begin failures++; $display("FAIL mem_lw_r6: addr=%h data=%h want 0000000c 00000005", st_addr[s0+1], st_data[s0+1]); end
    endtask

    task automatic test_ctrl_flow();
        int f0, r0, s0;
        logic [31:0] exp_fetch [0:9];
        logic [31:0] exp_r31;
        clear_prog();
        prog[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        prog[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'd7);
        prog[2]  = enc_i(6'h08, 5'd0, 5'd7, 16'd1);
        prog[3]  = enc_i(6'h04, 5'd1, 5'd2, 16'd1);
        prog[4]  = enc_i(6'h04, 5'd1, 5'd1, 16'd2);
        prog[7]  = enc_j(6'h02, 26'h8);
        prog[8]  = enc_j(6'h03, 26'h10);
        prog[9]  = enc_i(6'h2B, 5'd0, 5'd31, 16'd0);
        prog[16] = enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);
        exp_fetch[0] = 32'h00; exp_fetch[1] = 32'h04; exp_fetch[2] = 32'h08; exp_fetch[3] = 32'h0C;
        exp_fetch[4] = 32'h10; exp_fetch[5] = 32'h1C; exp_fetch[6] = 32'h20; exp_fetch[7] = 32'h40;
        exp_fetch[8] = 32'h24; exp_fetch[9] = 32'h28;
`ifdef CORE_LR_EN
        exp_r31 = 32'h0;
`else
        exp_r31 = 32'h24;
`endif
        f0 = nf; r0 = nr; s0 = nst;
        do_reset();
        run_to_halt("ctrl", 300);
        for (int i = 0; i < 10; i++) begin
            checks++; if (fetch_addr[f0+i] !== exp_fetch[i]) begin failures++; $display("FAIL ctrl_fetch%0d: got %h want %h", i, fetch_addr[f0+i], exp_fetch[i]); end
        end
        checks++; if (nr - r0 !== 9) begin failures++; $display("FAIL ctrl_retire_count: got %0d want 9", nr - r0); end
        checks++; if (ret_cyc[r0+4] - fetch_cyc[f0+4] + 1 !== 3) begin failures++; $display("FAIL ctrl_beq_latency: got %0d want 3", ret_cyc[r0+4] - fetch_cyc[f0+4] + 1); end
        checks++; if (ret_cyc[r0+6] - fetch_cyc[f0+6] + 1 !== 4) begin failures++; $display("FAIL ctrl_jal_latency: got %0d want 4", ret_cyc[r0+6] - fetch_cyc[f0+6] + 1); end
        checks++; if (ret_cyc[r0+7] - fetch_cyc[f0+7] + 1 !== 3) begin failures++; $display("FAIL ctrl_jr_latency: got %0d want 3", ret_cyc[r0+7] - fetch_cyc[f0+7] + 1); end
        checks++; if (st_data[s0] !== exp_r31) begin failures++; $display("FAIL ctrl_r31: got %h want %h", st_data[s0], exp_r31); end
    endtask

    task automatic test_illegal();
        int f0, r0, h0;
        clear_prog();
        prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
        prog[1] = enc_j(6'h3E, 26'h0);
        prog[2] = enc_i(6'h08, 5'd0, 5'd2, 16'd2);
        f0 = nf; r0 = nr;
        do_reset();
        run_to_halt("illegal_op", 100);
        h0 = req_after_halt;
        repeat (6) tick();
        checks++; if (halted !== 1'b1 || illegal !== 1'b1) begin failures++; $display("FAIL illegal_op_status: halted=%b illegal=%b want 1 1", halted, illegal); end
        checks++; if (pc_out !== 32'h4) begin failures++; $display("FAIL illegal_op_pc: got %h want 00000004", pc_out); end
        checks++; if (nr - r0 !== 1 || nf - f0 !== 2) begin failures++; $display("FAIL illegal_op_activity: retires=%0d fetches=%0d want 1 2", nr - r0, nf - f0); end
        checks++; if (req_after_halt !== h0) begin failures++; $display("FAIL illegal_op_quiet: reqs=%0d want %0d", req_after_halt, h0); end
        clear_prog();
        prog[0] = enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h3F);
        r0 = nr;
        do_reset();
        run_to_halt("illegal_funct", 100);
        checks++; if (illegal !== 1'b1 || nr - r0 !== 0) begin failures++; $display("FAIL illegal_funct: illegal=%b retires=%0d want 1 0", illegal, nr - r0); end
    endtask

    task automatic test_reset_mid_fetch();
        int f0, s0, n;
        load_alu_prog();
        f0 = nf; s0 = nst;
        do_reset();
        n = 0;
        while (nf - f0 < 2 && n < 50) begin tick(); n++; end
        ihold = 1'b1;
        n = 0;
        while (!(imem_req === 1'b1 && imem_addr === 32'h8) && n < 20) begin tick(); n++; end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin failures++; $display("FAIL midrst_pending: req=%b addr=%h want 1 00000008", imem_req, imem_addr); end
        rst = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b0 || pc_out !== 32'h0) begin failures++; $display("FAIL midrst_abandon: req=%b pc=%h want 0 00000000", imem_req, pc_out); end
        rst = 1'b0;
        ihold = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL midrst_restart: req=%b addr=%h want 1 00000000", imem_req, imem_addr); end
        run_to_halt("midrst", 200);
        checks++; if (st_data[s0] !== 32'd2 || st_data[s0+2] !== 32'd20) begin failures++; $display("FAIL midrst_result: r3=%h r5=%h want 00000002 00000014", st_data[s0], st_data[s0+2]); end
    endtask

    initial begin
        imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0; dmem_rdata = '0;
        for (int i = 0; i < 16; i++) dm[i] = '0;
        test_reset();
        test_alu();
        test_mem_wait();
        test_ctrl_flow();
        test_illegal();
        test_reset_mid_fetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
